// File: rtl/bw_ctu_clk_div_seq_if.sv
// ----------------------------------------------------------------------------
// bw_ctu_clk_div_seq_if
// Bundle of control and phase-enable signals between one CTU clock-domain
// sequencer and its controller / sync mux.
//   en          : run (1) or park low (0) the divided clock
//   cfg_req     : new-ratio request, held until cfg_ack
//   cfg_ratio   : requested divide ratio in PLL cycles
//   cfg_ack     : one-cycle pulse when the new ratio takes effect
//   byp_req     : requested sync-mux select
//   sel         : registered select to the sync mux
//   div0 / div1 : rising / falling edge phase enables
//   cur_ratio   : ratio currently in effect
//   align_pulse : first cycle of each divided period
// master = controller side, slave = sequencer side.
// ----------------------------------------------------------------------------
interface bw_ctu_clk_div_seq_if #(
    parameter int RW = 5
);
    logic          en;
    logic          cfg_req;
    logic [RW-1:0] cfg_ratio;
    logic          cfg_ack;
    logic          byp_req;
    logic          sel;
    logic          div0;
    logic          div1;
    logic [RW-1:0] cur_ratio;
    logic          align_pulse;

    modport master (
        output en, cfg_req, cfg_ratio, byp_req,
        input  cfg_ack, sel, div0, div1, cur_ratio, align_pulse
    );

    modport slave (
        input  en, cfg_req, cfg_ratio, byp_req,
        output cfg_ack, sel, div0, div1, cur_ratio, align_pulse
    );
endinterface

// File: rtl/bw_ctu_clk_div_seq.sv
// ----------------------------------------------------------------------------
// bw_ctu_clk_div_seq
// Phase-enable sequencer for one sync-mux clock path. Produces div0 (captured
// on the PLL rising edge) and div1 (captured on the falling edge) so that the
// mux output is a divide-by-R clock with 50% duty at half-cycle resolution.
// Ratio changes, parking and select changes are only taken at the last cycle
// of a period, where both enables are low, so the mux output never glitches.
// Ports:
//   pll_clk_out : PLL clock, all flops on its rising edge
//   rst_l       : asynchronous active-low reset
//   bus         : slave side of bw_ctu_clk_div_seq_if (control + outputs)
// All outputs are driven straight from flops.
// ----------------------------------------------------------------------------
module bw_ctu_clk_div_seq #(
    parameter int RW        = 5,
    parameter int RST_RATIO = 4
) (
    input  logic                      pll_clk_out,
    input  logic                      rst_l,
    bw_ctu_clk_div_seq_if.slave       bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [RW-1:0] RATIO_MIN   = RW'(2);
    localparam logic [RW-1:0] RATIO_RESET = RW'(RST_RATIO);

    // Ratios below 2 cannot produce a low phase at the period boundary.
    function automatic logic [RW-1:0] clamp_ratio(input logic [RW-1:0] r);
        if (r < RATIO_MIN) begin
            return RATIO_MIN;
        end else begin
            return r;
        end
    endfunction

    state_t        state_q, state_d;
    logic [RW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] cur_ratio_q, cur_ratio_d;
    logic          sel_q, sel_d;
    logic          cfg_ack_q, cfg_ack_d;
    logic          div0_q, div0_d;
    logic          div1_q, div1_d;
    logic          align_q, align_d;

    logic          cfg_pending_s;
    logic          boundary_s;
    logic          run_next_s;
    logic [RW:0]   half_up_s;
    logic [RW:0]   half_dn_s;

    // A request still high during its own ack cycle is the same request.
    assign cfg_pending_s = bus.cfg_req & ~cfg_ack_q;
    assign boundary_s    = (state_q == ST_RUN) && (cnt_q == (cur_ratio_q - RW'(1)));

    // Next-state, counter, ratio/select update and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_ratio_d = cur_ratio_q;
        sel_d       = sel_q;
        cfg_ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = {RW{1'b0}};
                sel_d = bus.byp_req;
                if (cfg_pending_s) begin
                    cur_ratio_d = clamp_ratio(bus.cfg_ratio);
                    cfg_ack_d   = 1'b1;
                end else begin
                    cur_ratio_d = cur_ratio_q;
                end
                if (bus.en) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (boundary_s) begin
                    cnt_d = {RW{1'b0}};
                    sel_d = bus.byp_req;
                    if (cfg_pending_s) begin
                        cur_ratio_d = clamp_ratio(bus.cfg_ratio);
                        cfg_ack_d   = 1'b1;
                    end else begin
                        cur_ratio_d = cur_ratio_q;
                    end
                    if (bus.en) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + RW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {RW{1'b0}};
            end
        endcase

        // Outputs are registered, so decode them from the next cycle's
        // state, count and ratio; one extra bit keeps R+1 from overflowing.
        run_next_s = (state_d == ST_RUN);
        half_up_s  = ({1'b0, cur_ratio_d} + (RW+1)'(1)) >> 1;
        half_dn_s  = {1'b0, cur_ratio_d} >> 1;
        div0_d     = run_next_s && ({1'b0, cnt_d} < half_up_s);
        div1_d     = run_next_s && ({1'b0, cnt_d} < half_dn_s);
        align_d    = run_next_s && (cnt_d == {RW{1'b0}});
    end

    // State, counter, ratio and registered outputs.
    always_ff @(posedge pll_clk_out or negedge rst_l) begin
        if (!rst_l) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {RW{1'b0}};
            cur_ratio_q <= RATIO_RESET;
            sel_q       <= 1'b0;
            cfg_ack_q   <= 1'b0;
            div0_q      <= 1'b0;
            div1_q      <= 1'b0;
            align_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_ratio_q <= cur_ratio_d;
            sel_q       <= sel_d;
            cfg_ack_q   <= cfg_ack_d;
            div0_q      <= div0_d;
            div1_q      <= div1_d;
            align_q     <= align_d;
        end
    end

    assign bus.cfg_ack     = cfg_ack_q;
    assign bus.sel         = sel_q;
    assign bus.div0        = div0_q;
    assign bus.div1        = div1_q;
    assign bus.cur_ratio   = cur_ratio_q;
    assign bus.align_pulse = align_q;

endmodule

// File: tb/tb_bw_ctu_clk_div_seq.sv
// ----------------------------------------------------------------------------
// tb_bw_ctu_clk_div_seq
// Directed bench for bw_ctu_clk_div_seq (RW=5, RST_RATIO=4). Each step pushes
// the outputs expected after the next rising edge to a queue; the head is
// popped and compared 1 time unit after the edge.
// ----------------------------------------------------------------------------
module tb_bw_ctu_clk_div_seq;

    localparam int RW = 5;

    typedef struct {
        string          tag;
        logic           d0;
        logic           d1;
        logic           al;
        logic           sl;
        logic           ack;
        logic [RW-1:0]  cr;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_l = 1'b1;

    int pass_cnt  = 0;
    int total_cnt = 0;
    exp_t exp_q[$];

    bw_ctu_clk_div_seq_if #(.RW(RW)) ifc_bus ();

    bw_ctu_clk_div_seq #(.RW(RW), .RST_RATIO(4)) dut (
        .pll_clk_out (clk),
        .rst_l       (rst_l),
        .bus         (ifc_bus)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input string fld,
                        input logic [RW-1:0] got, input logic [RW-1:0] want);
        total_cnt++;
        assert (got === want) pass_cnt++;
        else $error("FAIL %s.%s: got %0h expected %0h", tag, fld, got, want);
    endtask

    task automatic push(input string tag, input logic d0, input logic d1,
                        input logic al, input logic sl, input logic ack,
                        input logic [RW-1:0] cr);
        exp_t e;
        e.tag = tag; e.d0 = d0; e.d1 = d1; e.al = al;
        e.sl = sl; e.ack = ack; e.cr = cr;
        exp_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (exp_q.size() == 0) begin
            total_cnt++;
            $error("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = exp_q.pop_front();
            chk1(e.tag, "div0",        RW'(ifc_bus.div0),        RW'(e.d0));
            chk1(e.tag, "div1",        RW'(ifc_bus.div1),        RW'(e.d1));
            chk1(e.tag, "align_pulse", RW'(ifc_bus.align_pulse), RW'(e.al));
            chk1(e.tag, "sel",         RW'(ifc_bus.sel),         RW'(e.sl));
            chk1(e.tag, "cfg_ack",     RW'(ifc_bus.cfg_ack),     RW'(e.ack));
            chk1(e.tag, "cur_ratio",   ifc_bus.cur_ratio,        e.cr);
        end
    endtask

    // Compare without a clock edge (asynchronous reset effects).
    task automatic now_chk(input string tag, input logic d0, input logic d1,
                           input logic al, input logic sl, input logic ack,
                           input logic [RW-1:0] cr);
        push(tag, d0, d1, al, sl, ack, cr);
        pop_compare();
    endtask

    // Advance one PLL cycle and compare.
    task automatic step(input string tag, input logic d0, input logic d1,
                        input logic al, input logic sl, input logic ack,
                        input logic [RW-1:0] cr);
        push(tag, d0, d1, al, sl, ack, cr);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    // n RUN cycles at ratio r starting from index c0, no ack expected.
    task automatic run_cycles(input string tag, input int r, input int c0,
                              input int n, input logic sl);
        int c;
        c = c0;
        for (int i = 0; i < n; i++) begin
            step(tag, (c < ((r + 1) >> 1)), (c < (r >> 1)), (c == 0), sl, 1'b0, RW'(r));
            c = (c == r - 1) ? 0 : c + 1;
        end
    endtask

    initial begin
        ifc_bus.en        = 1'b0;
        ifc_bus.cfg_req   = 1'b0;
        ifc_bus.cfg_ratio = 5'd0;
        ifc_bus.byp_req   = 1'b0;

        #1 rst_l = 1'b0;
        #2 now_chk("rst_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        @(posedge clk);
        #1 now_chk("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        rst_l = 1'b1;
        step("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);

        // R=4 run: 1,1,0,0 on both enables, align every 4th cycle.
        ifc_bus.en = 1'b1;
        run_cycles("r4", 4, 0, 8, 1'b0);
        ifc_bus.en = 1'b0;
        step("park",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        step("park2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);

        // Ratio 3 applied while parked; request held through ack is ignored.
        ifc_bus.cfg_req   = 1'b1;
        ifc_bus.cfg_ratio = 5'd3;
        step("idle_ack",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
        ifc_bus.cfg_ratio = 5'd5;
        step("ack_ignore", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3);
        ifc_bus.cfg_req   = 1'b0;
        ifc_bus.en        = 1'b1;
        run_cycles("r3", 3, 0, 6, 1'b0);

        // Back to R=4 at the boundary, then request 6 at cnt=1.
        ifc_bus.cfg_req   = 1'b1;
        ifc_bus.cfg_ratio = 5'd4;
        step("to_r4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4);
        ifc_bus.cfg_req   = 1'b0;
        step("r4_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4);
        ifc_bus.cfg_req   = 1'b1;
        ifc_bus.cfg_ratio = 5'd6;
        step("hold_c2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        step("hold_c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        step("r6_ack",  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6);
        ifc_bus.cfg_req   = 1'b0;
        run_cycles("r6", 6, 1, 5, 1'b0);
        step("r6_p2c0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6);

        // byp_req rise at cnt=0: sel only moves after the boundary.
        ifc_bus.byp_req = 1'b1;
        run_cycles("byp_wait", 6, 1, 5, 1'b0);
        step("sel_rise", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd6);
        ifc_bus.byp_req = 1'b0;
        run_cycles("byp_fall_wait", 6, 1, 4, 1'b1);
        // At the boundary: sel fall and ratio change together.
        ifc_bus.cfg_req   = 1'b1;
        ifc_bus.cfg_ratio = 5'd4;
        step("r6_c5", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd6);
        step("sel_fall_r4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4);
        ifc_bus.cfg_req   = 1'b0;

        // en drop mid-period completes the period, then parks.
        step("r4b_c1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4);
        ifc_bus.en = 1'b0;
        step("drain_c2",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        step("drain_c3",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        step("idle_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);

        // Ratio 1 clamps to 2; R=2 alternates 1,0.
        ifc_bus.cfg_req   = 1'b1;
        ifc_bus.cfg_ratio = 5'd1;
        step("clamp",      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2);
        ifc_bus.cfg_req   = 1'b0;
        step("clamp_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2);
        ifc_bus.en = 1'b1;
        run_cycles("r2", 2, 0, 4, 1'b0);

        // R=5 with bypass, then reset at cnt=2.
        ifc_bus.cfg_req   = 1'b1;
        ifc_bus.cfg_ratio = 5'd5;
        ifc_bus.byp_req   = 1'b1;
        step("r5_sel", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd5);
        ifc_bus.cfg_req   = 1'b0;
        step("r5_c1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5);
        step("r5_c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd5);
        #2 rst_l = 1'b0;
        #1 now_chk("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd4);
        #2 rst_l = 1'b1;
        step("post_rst_c0", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd4);
        run_cycles("post_rst", 4, 1, 4, 1'b1);

        total_cnt++;
        assert (exp_q.size() == 0) pass_cnt++;
        else $error("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
